// File: rtl/setup_reg_if.sv
// rtl/setup_reg_if.sv - serial setup-word load bus between the driver and setup_reg
// The parity_in/parity_err pair exists only when SETUP_REG_PARITY_EN is defined.
interface setup_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             en_in;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             frame_done;
  logic [CNT_W-1:0] bit_count;
`ifdef SETUP_REG_PARITY_EN
  logic             parity_in;
  logic             parity_err;

  modport master (
    output en_in, serial_in, parity_in,
    input  parallel_out, frame_done, bit_count, parity_err
  );
  modport slave (
    input  en_in, serial_in, parity_in,
    output parallel_out, frame_done, bit_count, parity_err
  );
`else
  modport master (
    output en_in, serial_in,
    input  parallel_out, frame_done, bit_count
  );
  modport slave (
    input  en_in, serial_in,
    output parallel_out, frame_done, bit_count
  );
`endif
endinterface

// File: rtl/setup_reg.sv
// rtl/setup_reg.sv - serial-in parallel-out setup shift register, LSB first, with word-done pulse
// Optional even-parity check of each assembled word when SETUP_REG_PARITY_EN is defined.
module setup_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  setup_reg_if.slave  bus
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             last_bit;

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign sr_next  = {bus.serial_in, sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.en_in) begin
        sr_q <= sr_next;
        if (last_bit) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef SETUP_REG_PARITY_EN
  logic perr_q;

  // Error flag shares the frame_done cycle; it compares the completed word, not the old contents.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= bus.en_in && last_bit && ((^sr_next) != bus.parity_in);
    end
  end

  assign bus.parity_err = perr_q;
`endif

  assign bus.parallel_out = sr_q;
  assign bus.bit_count    = cnt_q;
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_setup_reg.sv
// tb/tb_setup_reg.sv - scoreboard bench for setup_reg (reset, word load, gating, mid-word reset, wrap)
// Parity checks are compiled in only when SETUP_REG_PARITY_EN is defined.
module tb_setup_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef struct {
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  setup_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  setup_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  exp_t             exp_q[$];
  logic [WIDTH-1:0] word_q[$];
  logic [WIDTH-1:0] m_sr;
  logic [CNT_W-1:0] m_cnt;
  logic [WIDTH-1:0] tgt_word;
  int               n_checks = 0;
  int               n_pass = 0;
  int               done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge.
  task automatic step(input logic en, input logic b, input logic p);
    exp_t e;
    exp_t o;
    logic [WIDTH-1:0] w;
    bus.en_in     = en;
    bus.serial_in = b;
`ifdef SETUP_REG_PARITY_EN
    bus.parity_in = p;
`endif
    e.done = 1'b0;
    e.perr = 1'b0;
    if (!rst_n) begin
      m_sr  = '0;
      m_cnt = '0;
    end else if (en) begin
      m_sr = {b, m_sr[WIDTH-1:1]};
      if (m_cnt == CNT_W'(WIDTH - 1)) begin
        m_cnt  = '0;
        e.done = 1'b1;
`ifdef SETUP_REG_PARITY_EN
        e.perr = ((^m_sr) != p);
`endif
        word_q.push_back(tgt_word);
      end else begin
        m_cnt = m_cnt + CNT_W'(1);
      end
    end
    e.sr  = m_sr;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = exp_q.pop_front();
    check("parallel_out", 32'(bus.parallel_out), 32'(o.sr));
    check("bit_count", 32'(bus.bit_count), 32'(o.cnt));
    check("frame_done", 32'(bus.frame_done), 32'(o.done));
`ifdef SETUP_REG_PARITY_EN
    check("parity_err", 32'(bus.parity_err), 32'(o.perr));
`endif
    if (bus.frame_done) begin
      done_seen++;
      if (word_q.size() == 0) begin
        check("unexpected_frame", 32'(1), 32'(0));
      end else begin
        w = word_q.pop_front();
        check("word", 32'(bus.parallel_out), 32'(w));
      end
    end
  endtask

  task automatic shift_bits(input logic [WIDTH-1:0] w, input int lo, input int hi, input logic p);
    tgt_word = w;
    for (int i = lo; i <= hi; i++) step(1'b1, w[i], p);
  endtask

  int d0;

  initial begin
    bus.en_in     = 1'b0;
    bus.serial_in = 1'b0;
`ifdef SETUP_REG_PARITY_EN
    bus.parity_in = 1'b0;
`endif
    m_sr     = '0;
    m_cnt    = '0;
    tgt_word = '0;
    @(negedge clk);

    // Reset dominates a toggling, enabled input.
    for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0);
    check("reset_out", 32'(bus.parallel_out), 32'h0);

    rst_n = 1'b1;
    shift_bits(8'h00, 0, 7, 1'b0);
    shift_bits(8'hAA, 0, 7, 1'b0);
    shift_bits(8'hFF, 0, 7, 1'b0);
    shift_bits(8'hF0, 0, 7, 1'b0);
    shift_bits(8'h0F, 0, 7, 1'b0);
    check("word_load_last", 32'(bus.parallel_out), 32'h0F);

    // Enable gap mid-word.
    d0 = done_seen;
    shift_bits(8'hA5, 0, 3, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    check("gap_count", 32'(bus.bit_count), 32'd4);
    shift_bits(8'hA5, 4, 7, 1'b0);
    check("gap_word", 32'(bus.parallel_out), 32'hA5);
    check("gap_frames", 32'(done_seen - d0), 32'd1);

    // Asynchronous reset pulse between edges.
    shift_bits(8'h5A, 0, 2, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(bus.parallel_out), 32'h0);
    check("async_rst_cnt", 32'(bus.bit_count), 32'h0);
    rst_n = 1'b1;
    m_sr  = '0;
    m_cnt = '0;
    shift_bits(8'h3C, 0, 7, 1'b0);
    check("after_rst_word", 32'(bus.parallel_out), 32'h3C);

    // Counter wrap over two words.
    d0 = done_seen;
    shift_bits(8'h69, 0, 7, 1'b0);
    shift_bits(8'hC3, 0, 7, 1'b0);
    check("wrap_frames", 32'(done_seen - d0), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    check("idle_done", 32'(bus.frame_done), 32'd0);

`ifdef SETUP_REG_PARITY_EN
    shift_bits(8'h0F, 0, 7, 1'b0);
    check("parity_ok", 32'(bus.parity_err), 32'd0);
    shift_bits(8'h07, 0, 7, 1'b0);
    check("parity_bad", 32'(bus.parity_err), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("parity_clear", 32'(bus.parity_err), 32'd0);
`endif

    check("scoreboard_empty", 32'(exp_q.size() + word_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
